// File: rtl/vga_timing_pkg.sv
// Shared 640x480 @ 60 Hz VGA timing constants.
// Used by vga_sync and by every drawing object that consumes pixel coordinates.
package vga_timing_pkg;

    // Coordinate width shared by the timing generator and the drawing objects
    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // Horizontal timing, in pixels
    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    // Vertical timing, in lines
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // True when val lies in the inclusive window [lo, hi]
    function automatic logic in_window(input coord_t val, input coord_t lo, input coord_t hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_tick_div.sv
// Divide-by-2 pixel enable generator.
// Produces a one-iclk-wide enable every second iclk edge; the first
// enable appears after the first edge following reset release, so the
// counters first advance on the second edge.
module vga_tick_div (
    input  logic iclk,
    input  logic ireset,
    output logic otick
);

    logic tick_reg;

    // Toggle flop; cleared asynchronously so the phase after reset is fixed
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= ~tick_reg;
        end
    end

    assign otick = tick_reg;

endmodule

// File: rtl/vga_sync.sv
// VGA sync / coordinate generator (640x480 @ 60 Hz by default).
// Compile-time option VGA_SYNC_PIX_DIV_EN: when defined, a divide-by-2
// enable (vga_tick_div) lets the block run from a 50 MHz clock; when
// undefined the pixel enable is tied high and iclk is the 25 MHz pixel clock.
// Sync outputs are registered from the decode of the next counter values so
// they change on the same edge as the coordinates and never glitch.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int H_DISP = H_DISPLAY,
    parameter int H_FP   = H_FRONT,
    parameter int H_SW   = H_SYNC,
    parameter int H_BP   = H_BACK,
    parameter int V_DISP = V_DISPLAY,
    parameter int V_FP   = V_FRONT,
    parameter int V_SW   = V_SYNC,
    parameter int V_BP   = V_BACK
) (
    input  logic               iclk,
    input  logic               ireset,
    output logic               ohsync,
    output logic               ovsync,
    output logic               ovideo_on,
    output logic               opixel_tick,
    output logic [COORD_W-1:0] opixel_x,
    output logic [COORD_W-1:0] opixel_y,
    output logic               oframe_end
);

    // Derived boundaries, sized to the coordinate width
    localparam coord_t H_VIS     = coord_t'(H_DISP);
    localparam coord_t H_LAST    = coord_t'(H_DISP + H_FP + H_SW + H_BP - 1);
    localparam coord_t H_SYNC_LO = coord_t'(H_DISP + H_FP);
    localparam coord_t H_SYNC_HI = coord_t'(H_DISP + H_FP + H_SW - 1);
    localparam coord_t V_VIS     = coord_t'(V_DISP);
    localparam coord_t V_LAST    = coord_t'(V_DISP + V_FP + V_SW + V_BP - 1);
    localparam coord_t V_SYNC_LO = coord_t'(V_DISP + V_FP);
    localparam coord_t V_SYNC_HI = coord_t'(V_DISP + V_FP + V_SW - 1);

    logic   pixel_tick;
    coord_t h_reg, h_next;
    coord_t v_reg, v_next;
    logic   hsync_reg, hsync_next;
    logic   vsync_reg, vsync_next;
    logic   h_wrap;

`ifdef VGA_SYNC_PIX_DIV_EN
    vga_tick_div u_tick_div (
        .iclk   (iclk),
        .ireset (ireset),
        .otick  (pixel_tick)
    );
`else
    assign pixel_tick = 1'b1;
`endif

    // Next-state for the counters and the active-low sync decodes
    always_comb begin
        h_next = h_reg;
        v_next = v_reg;
        h_wrap = pixel_tick && (h_reg == H_LAST);

        if (pixel_tick) begin
            h_next = h_wrap ? '0 : h_reg + coord_t'(1);
        end
        // v moves only on the edge where the line wraps, so the frame wrap
        // (last pixel, last line) -> (0,0) happens in one ticked edge
        if (h_wrap) begin
            v_next = (v_reg == V_LAST) ? '0 : v_reg + coord_t'(1);
        end

        hsync_next = ~in_window(h_next, H_SYNC_LO, H_SYNC_HI);
        vsync_next = ~in_window(v_next, V_SYNC_LO, V_SYNC_HI);
    end

    // Counter and sync registers; reset puts the raster at (0,0), syncs idle
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            h_reg     <= '0;
            v_reg     <= '0;
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
        end else begin
            h_reg     <= h_next;
            v_reg     <= v_next;
            hsync_reg <= hsync_next;
            vsync_reg <= vsync_next;
        end
    end

    assign opixel_x    = h_reg;
    assign opixel_y    = v_reg;
    assign ohsync      = hsync_reg;
    assign ovsync      = vsync_reg;
    assign opixel_tick = pixel_tick;
    assign ovideo_on   = (h_reg < H_VIS) && (v_reg < V_VIS);
    assign oframe_end  = pixel_tick && (h_reg == H_LAST) && (v_reg == V_LAST);

endmodule

// File: tb/tb_vga_sync.sv
// Directed testbench for vga_sync. A second instance with a shortened
// vertical timing (10 lines) exercises vsync and the frame wrap quickly.
module tb_vga_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       hsync, vsync, video_on, tick, fend;
    logic [9:0] px, py;
    logic       s_hsync, s_vsync, s_video_on, s_tick, s_fend;
    logic [9:0] s_px, s_py;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vga_sync dut (
        .iclk        (clk),
        .ireset      (rst),
        .ohsync      (hsync),
        .ovsync      (vsync),
        .ovideo_on   (video_on),
        .opixel_tick (tick),
        .opixel_x    (px),
        .opixel_y    (py),
        .oframe_end  (fend)
    );

    // Small frame: 4 visible lines, vsync on lines 6..7, last line 9
    vga_sync #(.V_DISP(4), .V_FP(2), .V_SW(2), .V_BP(2)) dut_s (
        .iclk        (clk),
        .ireset      (rst),
        .ohsync      (s_hsync),
        .ovsync      (s_vsync),
        .ovideo_on   (s_video_on),
        .opixel_tick (s_tick),
        .opixel_x    (s_px),
        .opixel_y    (s_py),
        .oframe_end  (s_fend)
    );

    // Wait (bounded) for a negedge at which the pixel enable is high
    task automatic wait_tick();
        int n = 0;
        while (tick !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        if (tick !== 1'b1) begin
            checks++; errors++;
            $display("FAIL tick_timeout: opixel_tick=%b required 1", tick);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (px !== 10'd0)     begin errors++; $display("FAIL reset_x: got %0d want 0", px); end
        checks++; if (py !== 10'd0)     begin errors++; $display("FAIL reset_y: got %0d want 0", py); end
        checks++; if (hsync !== 1'b1)   begin errors++; $display("FAIL reset_hsync: got %b want 1", hsync); end
        checks++; if (vsync !== 1'b1)   begin errors++; $display("FAIL reset_vsync: got %b want 1", vsync); end
        checks++; if (fend !== 1'b0)    begin errors++; $display("FAIL reset_fend: got %b want 0", fend); end
        checks++; if (video_on !== 1'b1) begin errors++; $display("FAIL reset_video_on: got %b want 1", video_on); end
`ifdef VGA_SYNC_PIX_DIV_EN
        checks++; if (tick !== 1'b0)    begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
`endif
        $display("test_reset: done");
        rst = 1'b0;
    endtask

    task automatic test_tick();
        do_reset();
        for (int k = 0; k < 8; k++) begin
`ifdef VGA_SYNC_PIX_DIV_EN
            checks++; if (tick !== 1'(k % 2)) begin errors++; $display("FAIL tick_phase k=%0d: got %b want %0d", k, tick, k % 2); end
            checks++; if (px !== 10'(k / 2))  begin errors++; $display("FAIL tick_hold k=%0d: x=%0d want %0d", k, px, k / 2); end
`else
            checks++; if (tick !== 1'b1)      begin errors++; $display("FAIL tick_const k=%0d: got %b want 1", k, tick); end
            checks++; if (px !== 10'(k))      begin errors++; $display("FAIL tick_step k=%0d: x=%0d want %0d", k, px, k); end
`endif
            @(negedge clk);
        end
        $display("test_tick: done");
    endtask

    task automatic test_line();
        int hs_low = 0;
        int first_low = -1;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            wait_tick();
            checks++; if (px !== 10'(i)) begin errors++; $display("FAIL line_x: got %0d want %0d", px, i); end
            checks++; if (py !== 10'd0)  begin errors++; $display("FAIL line_y at x=%0d: got %0d want 0", i, py); end
            checks++; if (hsync !== ((i >= 656 && i <= 751) ? 1'b0 : 1'b1))
                begin errors++; $display("FAIL line_hsync at x=%0d: got %b", i, hsync); end
            checks++; if (video_on !== ((i < 640) ? 1'b1 : 1'b0))
                begin errors++; $display("FAIL line_video_on at x=%0d: got %b", i, video_on); end
            if (hsync === 1'b0) begin
                hs_low++;
                if (first_low < 0) first_low = int'(px);
            end
            @(negedge clk);
        end
        wait_tick();
        checks++; if (px !== 10'd0)   begin errors++; $display("FAIL line_wrap_x: got %0d want 0", px); end
        checks++; if (py !== 10'd1)   begin errors++; $display("FAIL line_wrap_y: got %0d want 1", py); end
        checks++; if (hs_low != 96)   begin errors++; $display("FAIL hsync_width: got %0d want 96", hs_low); end
        checks++; if (first_low != 656) begin errors++; $display("FAIL hsync_start: got %0d want 656", first_low); end
        $display("test_line: hsync low %0d ticks from x=%0d", hs_low, first_low);
    endtask

    task automatic test_frame();
        int vs_low = 0;
        int visible = 0;
        int fend_cnt = 0;
        do_reset();
        for (int n = 0; n < 8000; n++) begin
            wait_tick();
            checks++; if (s_px !== 10'(n % 800) || s_py !== 10'(n / 800))
                begin errors++; $display("FAIL frame_xy n=%0d: got (%0d,%0d) want (%0d,%0d)", n, s_px, s_py, n % 800, n / 800); end
            checks++; if (s_vsync !== ((n / 800 == 6 || n / 800 == 7) ? 1'b0 : 1'b1))
                begin errors++; $display("FAIL frame_vsync n=%0d: got %b", n, s_vsync); end
            checks++; if (s_video_on !== ((n % 800 < 640 && n / 800 < 4) ? 1'b1 : 1'b0))
                begin errors++; $display("FAIL frame_video_on n=%0d: got %b", n, s_video_on); end
            checks++; if (s_fend !== ((n == 7999) ? 1'b1 : 1'b0))
                begin errors++; $display("FAIL frame_end n=%0d: got %b", n, s_fend); end
            if (s_vsync === 1'b0) vs_low++;
            if (s_video_on === 1'b1) visible++;
            if (s_fend === 1'b1) fend_cnt++;
            @(negedge clk);
            if (tick === 1'b0) begin
                checks++; if (s_fend !== 1'b0) begin errors++; $display("FAIL fend_width n=%0d: got %b want 0", n, s_fend); end
            end
        end
        wait_tick();
        checks++; if (s_px !== 10'd0 || s_py !== 10'd0)
            begin errors++; $display("FAIL frame_wrap: got (%0d,%0d) want (0,0)", s_px, s_py); end
        checks++; if (vs_low != 1600)   begin errors++; $display("FAIL vsync_ticks: got %0d want 1600", vs_low); end
        checks++; if (visible != 2560)  begin errors++; $display("FAIL visible_ticks: got %0d want 2560", visible); end
        checks++; if (fend_cnt != 1)    begin errors++; $display("FAIL fend_count: got %0d want 1", fend_cnt); end
        $display("test_frame: vsync %0d ticks, visible %0d, frame_end %0d", vs_low, visible, fend_cnt);
    endtask

    task automatic test_mid_reset();
        int n = 0;
        do_reset();
        while (px !== 10'd700 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (px !== 10'd700) begin errors++; $display("FAIL mid_reach: x=%0d want 700", px); end
        checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL mid_hsync_pre: got %b want 0", hsync); end
        rst = 1'b1;
        #1;
        checks++; if (px !== 10'd0 || py !== 10'd0) begin errors++; $display("FAIL mid_async_xy: got (%0d,%0d) want (0,0)", px, py); end
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL mid_async_hsync: got %b want 1", hsync); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL mid_async_vsync: got %b want 1", vsync); end
        checks++; if (s_px !== 10'd0 || s_py !== 10'd0) begin errors++; $display("FAIL mid_async_small: got (%0d,%0d) want (0,0)", s_px, s_py); end
        repeat (3) @(negedge clk);
        checks++; if (px !== 10'd0 || fend !== 1'b0) begin errors++; $display("FAIL mid_hold: x=%0d fend=%b want 0/0", px, fend); end
        rst = 1'b0;
        wait_tick();
        checks++; if (px !== 10'd0 || py !== 10'd0) begin errors++; $display("FAIL mid_restart0: got (%0d,%0d) want (0,0)", px, py); end
        @(negedge clk);
        wait_tick();
        checks++; if (px !== 10'd1 || py !== 10'd0) begin errors++; $display("FAIL mid_restart1: got (%0d,%0d) want (1,0)", px, py); end
        $display("test_mid_reset: restarted at (%0d,%0d)", px, py);
    endtask

    initial begin
        test_reset();
        test_tick();
        test_line();
        test_frame();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
